// File: rtl/dbg_capture_ctrl_if.sv
// Bundle of the probed sample stream, the circular-buffer RAM ports and the
// host readout stream around dbg_capture_ctrl. The controller is the master.
interface dbg_capture_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 10
);
    logic              smp_vld;
    logic [WIDTH-1:0]  smp_dat;
    logic              trig;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_wr_addr;
    logic [WIDTH-1:0]  ram_dat_in;
    logic              ram_re;
    logic [AWIDTH-1:0] ram_rd_addr;
    logic [WIDTH-1:0]  ram_dat_out;
    logic              rd_req;
    logic [WIDTH-1:0]  rd_dat;
    logic              rd_vld;
    logic              rd_rdy;
    logic              rd_last;

    modport master (
        input  smp_vld, smp_dat, trig, ram_dat_out, rd_req, rd_rdy,
        output ram_we, ram_wr_addr, ram_dat_in, ram_re, ram_rd_addr,
               rd_dat, rd_vld, rd_last
    );

    modport slave (
        output smp_vld, smp_dat, trig, ram_dat_out, rd_req, rd_rdy,
        input  ram_we, ram_wr_addr, ram_dat_in, ram_re, ram_rd_addr,
               rd_dat, rd_vld, rd_last
    );
endinterface

// File: rtl/dbg_capture_ctrl.sv
// Trigger-based capture controller: streams samples into a circular RAM,
// keeps a pre-trigger window, stops after the post-trigger count and replays
// the captured window oldest-first through a valid/ready port.
module dbg_capture_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 1024,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [AWIDTH-1:0]  pre_len,
    input  logic [AWIDTH-1:0]  post_len,
    output logic               busy,
    output logic               done,
    output logic [AWIDTH-1:0]  cap_start,
    dbg_capture_ctrl_if.master bus
);
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE, READ} state_t;

    // A post length of zero still captures the trigger sample itself.
    function automatic logic [AWIDTH-1:0] post_effective(input logic [AWIDTH-1:0] len);
        return (len == '0) ? AWIDTH'(1) : len;
    endfunction

    // Shrink the pre-trigger window so the whole capture fits in the RAM.
    function automatic logic [AWIDTH-1:0] pre_clamped(input logic [AWIDTH-1:0] pre,
                                                      input logic [AWIDTH-1:0] post);
        logic [AWIDTH:0] sum;
        sum = {1'b0, pre} + {1'b0, post};
        return (sum > DEPTH_W) ? AWIDTH'(DEPTH_W - {1'b0, post}) : pre;
    endfunction

    state_t            state;
    logic [AWIDTH-1:0] wp, rp, fill, cnt, pre_eff, post_eff;
    logic [AWIDTH-1:0] arm_pre, arm_post;
    logic [AWIDTH:0]   remaining;
    logic              capturing, pop;
    logic              rd_inflight, rd_inflight_last;
    logic [1:0]        fifo_cnt, occ_after_pop;
    logic              fifo_head, wr_slot;
    logic [WIDTH-1:0]  fifo_dat [2];
    logic              fifo_last [2];

    assign arm_post  = post_effective(post_len);
    assign arm_pre   = pre_clamped(pre_len, arm_post);
    assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign busy      = capturing || (state == READ);
    assign done      = (state == DONE);

    // Write port is a zero-latency pass-through of the sample strobe.
    assign bus.ram_we      = capturing && bus.smp_vld;
    assign bus.ram_wr_addr = wp;
    assign bus.ram_dat_in  = bus.ram_we ? bus.smp_dat : '0;

    // Reads are throttled so buffered plus in-flight words never exceed two.
    assign pop           = bus.rd_vld && bus.rd_rdy;
    assign occ_after_pop = fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    assign bus.ram_re    = (state == READ) && (remaining != '0) && (occ_after_pop < 2'd2);
    assign bus.ram_rd_addr = rp;

    assign wr_slot     = fifo_head ^ fifo_cnt[0];
    assign bus.rd_vld  = (fifo_cnt != 2'd0);
    assign bus.rd_dat  = bus.rd_vld ? fifo_dat[fifo_head] : '0;
    assign bus.rd_last = bus.rd_vld && fifo_last[fifo_head];

    // Capture/readout sequencer with its pointers and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            fill      <= '0;
            cnt       <= '0;
            pre_eff   <= '0;
            post_eff  <= '0;
            remaining <= '0;
            cap_start <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            if (bus.ram_we) wp <= wp + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        pre_eff  <= arm_pre;
                        post_eff <= arm_post;
                        wp       <= '0;
                        fill     <= '0;
                        state    <= (arm_pre == '0) ? WAIT_TRIG : PRE;
                    end else if ((state == DONE) && bus.rd_req) begin
                        rp        <= cap_start;
                        remaining <= {1'b0, pre_eff} + {1'b0, post_eff};
                        state     <= READ;
                    end
                end
                PRE: begin
                    if (bus.smp_vld) begin
                        fill <= fill + 1'b1;
                        if (fill + 1'b1 == pre_eff) state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (bus.smp_vld && bus.trig) begin
                        cnt       <= AWIDTH'(1);
                        cap_start <= wp - pre_eff;
                        state     <= (post_eff == AWIDTH'(1)) ? DONE : POST;
                    end
                end
                POST: begin
                    if (bus.smp_vld) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == post_eff) state <= DONE;
                    end
                end
                READ: begin
                    if (bus.ram_re) begin
                        rp        <= rp + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                    if (pop && bus.rd_last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO occupancy and the one-cycle RAM read pipeline tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_cnt         <= 2'd0;
            fifo_head        <= 1'b0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else if (abort) begin
            fifo_cnt    <= 2'd0;
            fifo_head   <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight      <= bus.ram_re;
            rd_inflight_last <= bus.ram_re && (remaining == (AWIDTH+1)'(1));
            if (pop) fifo_head <= ~fifo_head;
            fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

    // Capture returning RAM words into the FIFO slot behind the tail.
    always_ff @(posedge clk) begin
        if (rd_inflight) begin
            fifo_dat[wr_slot]  <= bus.ram_dat_out;
            fifo_last[wr_slot] <= rd_inflight_last;
        end
    end
endmodule

// File: tb/tb_dbg_capture_ctrl.sv
// Bench for dbg_capture_ctrl with a behavioural RAM, table-driven captures,
// randomized captures against a sample-history model, and abort/reset cases.
module tb_dbg_capture_ctrl;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int AWIDTH = 4;

    typedef struct {
        int pre, post, div, early_lo, early_hi, trig_at, rdy_mode, abort_rd;
        int exp_first, exp_step, exp_len, exp_cap;
        bit rnd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic arm = 1'b0;
    logic abort = 1'b0;
    logic [AWIDTH-1:0] pre_len = '0;
    logic [AWIDTH-1:0] post_len = '0;
    logic busy, done;
    logic [AWIDTH-1:0] cap_start;

    int n_checks = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    int exp_cap_val;
    vec_t tab[8];

    dbg_capture_ctrl_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    dbg_capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .pre_len(pre_len), .post_len(post_len),
        .busy(busy), .done(done), .cap_start(cap_start), .bus(bus)
    );

    always #5 clk = ~clk;

    // Registered-read RAM, read data forced to zero without a read enable.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_dat_in;
        bus.ram_dat_out <= bus.ram_re ? mem[bus.ram_rd_addr] : '0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget exhausted", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Arm, stream samples until the model says the capture is complete,
    // then fill exp_q/exp_cap_val from the table or from the sample history.
    task automatic capture(input vec_t v, output bit ok);
        int pre_eff, post_eff, trig_idx, k, cyc_n, idx;
        logic [WIDTH-1:0] hist[$];
        logic vld, tg;
        logic [WIDTH-1:0] d;
        ok = 1'b0;
        post_eff = (v.post == 0) ? 1 : v.post;
        pre_eff  = (v.pre + post_eff > DEPTH) ? DEPTH - post_eff : v.pre;
        cyc();
        bus.smp_vld = 1'b0; bus.trig = 1'b0;
        pre_len = AWIDTH'(v.pre); post_len = AWIDTH'(v.post); arm = 1'b1;
        trig_idx = -1; k = 0; cyc_n = 0;
        while (!(trig_idx >= 0 && hist.size() == trig_idx + post_eff)) begin
            if (cyc_n >= 1000) begin
                fail_now("capture_timeout");
                return;
            end
            cyc();
            arm = 1'b0;
            idx = hist.size();
            if (v.rnd) begin
                vld = ($urandom_range(v.div - 1, 0) == 0);
                d   = WIDTH'($urandom);
                tg  = ($urandom_range(5, 0) == 0) || (idx >= pre_eff + 8);
            end else begin
                vld = ((k % v.div) == 0);
                d   = WIDTH'(k);
                tg  = (idx >= v.early_lo && idx <= v.early_hi) || (idx == v.trig_at);
            end
            bus.smp_vld = vld; bus.smp_dat = d; bus.trig = tg;
            @(negedge clk);
            check("cap_ram_we", 32'(bus.ram_we), 32'(vld));
            check("cap_busy", 32'(busy), 1);
            if (vld) begin
                check("cap_wr_addr", 32'(bus.ram_wr_addr), idx % DEPTH);
                check("cap_wr_dat", 32'(bus.ram_dat_in), 32'(d));
                hist.push_back(d);
                if (trig_idx < 0 && tg && idx >= pre_eff) trig_idx = idx;
            end
            k++; cyc_n++;
        end
        cyc();
        bus.smp_vld = 1'b0; bus.trig = 1'b0;
        exp_q.delete();
        if (v.rnd) begin
            for (int j = 0; j < pre_eff + post_eff; j++) exp_q.push_back(hist[trig_idx - pre_eff + j]);
            exp_cap_val = (trig_idx - pre_eff + DEPTH) % DEPTH;
        end else begin
            for (int j = 0; j < v.exp_len; j++) exp_q.push_back(WIDTH'(v.exp_first + j * v.exp_step));
            exp_cap_val = v.exp_cap;
        end
        @(negedge clk);
        check("cap_done", 32'(done), 1);
        check("cap_busy_after", 32'(busy), 0);
        check("cap_start", 32'(cap_start), exp_cap_val);
        ok = 1'b1;
    endtask

    // Request a readout and check every transferred word against exp_q.
    task automatic readout(input vec_t v);
        int got, r, ph;
        logic prev_stall, prev_last;
        logic [WIDTH-1:0] prev_dat;
        cyc();
        bus.rd_req = 1'b1; bus.rd_rdy = 1'b0;
        @(negedge clk);
        check("rd_vld_req_cycle", 32'(bus.rd_vld), 0);
        got = 0; r = 1; prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0;
        while (got < exp_q.size()) begin
            if (r > 300) begin
                fail_now("readout_timeout");
                return;
            end
            cyc();
            bus.rd_req = 1'b0;
            ph = (r - 1) % 6;
            case (v.rdy_mode)
                0:       bus.rd_rdy = 1'b1;
                1:       bus.rd_rdy = (ph == 0) || (ph == 3) || (ph == 4);
                default: bus.rd_rdy = ($urandom_range(1, 0) == 1);
            endcase
            if (v.abort_rd == r) begin
                abort = 1'b1;
                cyc();
                abort = 1'b0; bus.rd_rdy = 1'b0;
                @(negedge clk);
                check("abort_rd_vld", 32'(bus.rd_vld), 0);
                check("abort_ram_re", 32'(bus.ram_re), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                return;
            end
            @(negedge clk);
            if (r == 1) check("ram_re_t1", 32'(bus.ram_re), 1);
            if (r == 2) check("rd_vld_t2", 32'(bus.rd_vld), 0);
            if (r == 3) check("rd_vld_t3", 32'(bus.rd_vld), 1);
            check("rd_ram_we", 32'(bus.ram_we), 0);
            if (prev_stall) begin
                check("stall_vld", 32'(bus.rd_vld), 1);
                check("stall_dat", 32'(bus.rd_dat), 32'(prev_dat));
                check("stall_last", 32'(bus.rd_last), 32'(prev_last));
            end
            if (bus.rd_vld && bus.rd_rdy) begin
                check("rd_dat", 32'(bus.rd_dat), 32'(exp_q[got]));
                check("rd_last", 32'(bus.rd_last), 32'(got == exp_q.size() - 1));
                got++;
            end
            prev_stall = bus.rd_vld && !bus.rd_rdy;
            prev_dat   = bus.rd_dat;
            prev_last  = bus.rd_last;
            r++;
        end
        cyc();
        bus.rd_rdy = 1'b0;
        @(negedge clk);
        check("rd_end_done", 32'(done), 1);
        check("rd_end_vld", 32'(bus.rd_vld), 0);
        check("rd_end_ram_re", 32'(bus.ram_re), 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        capture(v, ok);
        if (ok) readout(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        bus.smp_vld = 1'b0; bus.smp_dat = '0; bus.trig = 1'b0;
        bus.rd_req = 1'b0; bus.rd_rdy = 1'b0;

        //          pre post div elo ehi trig rdy abrt first step len cap rnd
        tab[0] = '{4,  4,   1,  -1, -1, 10,  0,  -1,  6,    1,   8,  6,  1'b0};
        tab[1] = '{4,  4,   1,  1,  2,  7,   0,  -1,  3,    1,   8,  3,  1'b0};
        tab[2] = '{14, 4,   1,  -1, -1, 40,  0,  -1,  28,   1,   16, 12, 1'b0};
        tab[3] = '{4,  4,   1,  -1, -1, 10,  1,  -1,  6,    1,   8,  6,  1'b0};
        tab[4] = '{3,  2,   3,  -1, -1, 5,   0,  -1,  6,    3,   5,  2,  1'b0};
        tab[5] = '{0,  0,   1,  -1, -1, 3,   0,  -1,  3,    1,   1,  3,  1'b0};
        tab[6] = '{15, 0,   2,  -1, -1, 20,  1,  -1,  10,   2,   16, 5,  1'b0};
        tab[7] = '{2,  3,   1,  -1, -1, 4,   0,  4,   2,    1,   5,  2,  1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_wr_addr", 32'(bus.ram_wr_addr), 0);
        check("rst_dat_in", 32'(bus.ram_dat_in), 0);
        check("rst_ram_re", 32'(bus.ram_re), 0);
        check("rst_rd_addr", 32'(bus.ram_rd_addr), 0);
        check("rst_rd_dat", 32'(bus.rd_dat), 0);
        check("rst_rd_vld", 32'(bus.rd_vld), 0);
        check("rst_rd_last", 32'(bus.rd_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cap_start", 32'(cap_start), 0);
        cyc();
        reset_n = 1'b1;

        // rd_req while idle is ignored
        cyc(); bus.rd_req = 1'b1;
        cyc(); bus.rd_req = 1'b0;
        @(negedge clk);
        check("idle_rd_req_busy", 32'(busy), 0);
        check("idle_rd_req_re", 32'(bus.ram_re), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(tab[i]);
            if (i == 0) readout(tab[0]);
        end

        // abort in POST, with a live sample strobe
        cyc(); pre_len = AWIDTH'(2); post_len = AWIDTH'(8); arm = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(); arm = 1'b0;
            bus.smp_vld = 1'b1; bus.smp_dat = WIDTH'(i); bus.trig = (i == 3);
        end
        cyc(); bus.trig = 1'b0; abort = 1'b1;
        @(negedge clk);
        check("post_busy_before_abort", 32'(busy), 1);
        cyc(); abort = 1'b0;
        @(negedge clk);
        check("post_abort_we", 32'(bus.ram_we), 0);
        check("post_abort_busy", 32'(busy), 0);
        check("post_abort_done", 32'(done), 0);
        check("post_abort_vld", 32'(bus.rd_vld), 0);

        // arm and abort together: abort wins
        cyc(); arm = 1'b1; abort = 1'b1;
        cyc(); arm = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("arm_abort_busy", 32'(busy), 0);
        check("arm_abort_we", 32'(bus.ram_we), 0);
        cyc(); bus.smp_vld = 1'b0;

        run_vec(tab[0]);

        for (int n = 0; n < 6; n++) begin
            rv = '{0, 0, 1, -1, -1, -1, 2, -1, 0, 0, 0, 0, 1'b1};
            rv.pre  = int'($urandom_range(15, 0));
            rv.post = int'($urandom_range(15, 0));
            rv.div  = int'($urandom_range(3, 1));
            run_vec(rv);
        end

        // reset asserted mid-capture
        cyc(); pre_len = AWIDTH'(4); post_len = AWIDTH'(4); arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); arm = 1'b0; bus.smp_vld = 1'b1; bus.smp_dat = WIDTH'(i);
        end
        cyc(); reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_we", 32'(bus.ram_we), 0);
        check("rst_mid_busy", 32'(busy), 0);
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        check("rst_rel_we", 32'(bus.ram_we), 0);
        check("rst_rel_busy", 32'(busy), 0);
        check("rst_rel_done", 32'(done), 0);
        cyc(); bus.smp_vld = 1'b0;

        run_vec(tab[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
